// File: rtl/mem_port_arb_if.sv
// mem_port_arb_if: fetch, data and memory-side signals of the shared memory port arbiter.
interface mem_port_arb_if;
    logic        i_flush;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_gnt;
    logic        o_if_rvld;
    logic [31:0] o_if_rdata;
    logic        i_dm_req;
    logic        i_dm_wen;
    logic [31:0] i_dm_addr;
    logic [31:0] i_dm_wdata;
    logic [3:0]  i_dm_mask;
    logic        o_dm_gnt;
    logic        o_dm_rvld;
    logic [31:0] o_dm_rdata;
    logic        o_mem_req;
    logic        o_mem_wen;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_ready;
    logic        i_mem_rvld;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_flush, i_if_req, i_if_addr, i_dm_req, i_dm_wen, i_dm_addr, i_dm_wdata, i_dm_mask,
        input  i_mem_ready, i_mem_rvld, i_mem_rdata,
        output o_if_gnt, o_if_rvld, o_if_rdata, o_dm_gnt, o_dm_rvld, o_dm_rdata,
        output o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask
    );

    modport master (
        output i_flush, i_if_req, i_if_addr, i_dm_req, i_dm_wen, i_dm_addr, i_dm_wdata, i_dm_mask,
        output i_mem_ready, i_mem_rvld, i_mem_rdata,
        input  o_if_gnt, o_if_rvld, o_if_rdata, o_dm_gnt, o_dm_rvld, o_dm_rdata,
        input  o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask
    );
endinterface

// File: rtl/mem_port_arb.sv
// mem_port_arb: single-outstanding arbiter of the unified memory port between fetch and data stages.
module mem_port_arb #(
    parameter int unsigned MAX_D_BURST = 4
) (
    input logic           i_clk,
    input logic           i_rst_n,
    mem_port_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D, DRAIN_I} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       idle, if_elig, pick_d, pick_i, gnt_d, gnt_i, mem_req;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Data normally wins; a pending fetch is forced through once the data burst hits its limit.
    always_comb begin
        idle    = state_q == IDLE;
        if_elig = bus.i_if_req & ~bus.i_flush;
        pick_d  = bus.i_dm_req & ~(if_elig & (cnt_q == 4'(MAX_D_BURST)));
        pick_i  = ~pick_d & if_elig;
        gnt_d   = idle & pick_d & bus.i_mem_ready;
        gnt_i   = idle & pick_i & bus.i_mem_ready;
        cnt_d   = gnt_i ? '0 : !gnt_d ? cnt_q : !if_elig ? '0 : cnt_q + 4'(cnt_q != 4'hF);
        state_d = gnt_d ? WAIT_D :
                  gnt_i ? WAIT_I :
                  (!idle && bus.i_mem_rvld) ? IDLE :
                  (state_q == WAIT_I && bus.i_flush) ? DRAIN_I : state_q;
    end

    // Outputs are gated by reset so they read zero the moment reset asserts, whatever the inputs.
    always_comb begin
        mem_req         = i_rst_n & idle & (pick_d | pick_i);
        bus.o_mem_req   = mem_req;
        bus.o_mem_wen   = mem_req & pick_d & bus.i_dm_wen;
        bus.o_mem_addr  = !mem_req ? '0 : pick_d ? bus.i_dm_addr : bus.i_if_addr;
        bus.o_mem_wdata = (mem_req & pick_d) ? bus.i_dm_wdata : '0;
        bus.o_mem_mask  = !mem_req ? '0 : pick_d ? bus.i_dm_mask : 4'hF;
        bus.o_dm_gnt    = i_rst_n & gnt_d;
        bus.o_if_gnt    = i_rst_n & gnt_i;
        bus.o_dm_rvld   = i_rst_n & (state_q == WAIT_D) & bus.i_mem_rvld;
        bus.o_if_rvld   = i_rst_n & (state_q == WAIT_I) & bus.i_mem_rvld & ~bus.i_flush;
        bus.o_dm_rdata  = bus.o_dm_rvld ? bus.i_mem_rdata : '0;
        bus.o_if_rdata  = bus.o_if_rvld ? bus.i_mem_rdata : '0;
    end
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: vector table for IDLE arbitration plus scoreboarded multi-cycle sequences.
module tb_mem_port_arb;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] if_q[$];
    logic [31:0] dm_q[$];

    mem_port_arb_if b();
    mem_port_arb #(.MAX_D_BURST(4)) dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(b));

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        flush, if_req, dm_req, dm_wen, ready;
        logic        e_req, e_wen;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_mask;
        logic        e_ign, e_dgn;
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic resp(input logic [31:0] d, input logic e_if, input logic e_dm);
        b.i_mem_rvld = 1'b1;
        b.i_mem_rdata = d;
        #2;
        chk("resp_if_rvld", {31'b0, b.o_if_rvld}, {31'b0, e_if});
        chk("resp_dm_rvld", {31'b0, b.o_dm_rvld}, {31'b0, e_dm});
        chk("resp_mem_req", {31'b0, b.o_mem_req}, 0);
        tick();
        b.i_mem_rvld = 1'b0;
        b.i_mem_rdata = '0;
    endtask

    task automatic zero_outs(input string p);
        chk({p, "_mem_req"}, {31'b0, b.o_mem_req}, 0);
        chk({p, "_mem_wen"}, {31'b0, b.o_mem_wen}, 0);
        chk({p, "_mem_addr"}, b.o_mem_addr, 0);
        chk({p, "_mem_wdata"}, b.o_mem_wdata, 0);
        chk({p, "_mem_mask"}, {28'b0, b.o_mem_mask}, 0);
        chk({p, "_if_gnt"}, {31'b0, b.o_if_gnt}, 0);
        chk({p, "_dm_gnt"}, {31'b0, b.o_dm_gnt}, 0);
        chk({p, "_if_rvld"}, {31'b0, b.o_if_rvld}, 0);
        chk({p, "_dm_rvld"}, {31'b0, b.o_dm_rvld}, 0);
        chk({p, "_if_rdata"}, b.o_if_rdata, 0);
        chk({p, "_dm_rdata"}, b.o_dm_rdata, 0);
    endtask

    // Response scoreboard: every rvld pulse must match the next expected word of its owner.
    always @(negedge i_clk) begin
        if (b.o_if_rvld) begin
            if (if_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL if_rvld_unexpected: got rdata %h expected no response", b.o_if_rdata);
            end else chk("if_rdata", b.o_if_rdata, if_q.pop_front());
        end else chk("if_rdata_idle", b.o_if_rdata, 0);
        if (b.o_dm_rvld) begin
            if (dm_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL dm_rvld_unexpected: got rdata %h expected no response", b.o_dm_rdata);
            end else chk("dm_rdata", b.o_dm_rdata, dm_q.pop_front());
        end else chk("dm_rdata_idle", b.o_dm_rdata, 0);
    end

    initial begin
        b.i_flush = 0; b.i_if_req = 1; b.i_if_addr = 32'h104; b.i_dm_req = 1; b.i_dm_wen = 0;
        b.i_dm_addr = 32'h2000; b.i_dm_wdata = 32'h55AA; b.i_dm_mask = 4'b0110;
        b.i_mem_ready = 1; b.i_mem_rvld = 0; b.i_mem_rdata = 0;
        #3;
        zero_outs("reset");
        b.i_if_req = 0; b.i_dm_req = 0; b.i_mem_ready = 0;
        tick(); tick();
        i_rst_n = 1'b1;

        //          flush   if_req  dm_req  wen     ready   req     wen     addr        wdata       mask     ign     dgn
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,    4'h0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h104,  32'h0,    4'hF, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h55AA, 4'h6, 1'b0, 1'b0};
        vt[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2000, 32'h55AA, 4'h6, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h55AA, 4'h6, 1'b0, 1'b0};
        vt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,    4'h0, 1'b0, 1'b0};
        vt[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2000, 32'h55AA, 4'h6, 1'b0, 1'b0};
        vt[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,    4'h0, 1'b0, 1'b0};
        vt[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    32'h0,    4'h0, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            b.i_flush = vt[i].flush; b.i_if_req = vt[i].if_req; b.i_dm_req = vt[i].dm_req;
            b.i_dm_wen = vt[i].dm_wen; b.i_mem_ready = vt[i].ready;
            #2;
            chk($sformatf("vec%0d_req", i), {31'b0, b.o_mem_req}, {31'b0, vt[i].e_req});
            chk($sformatf("vec%0d_wen", i), {31'b0, b.o_mem_wen}, {31'b0, vt[i].e_wen});
            chk($sformatf("vec%0d_addr", i), b.o_mem_addr, vt[i].e_addr);
            chk($sformatf("vec%0d_wdata", i), b.o_mem_wdata, vt[i].e_wdata);
            chk($sformatf("vec%0d_mask", i), {28'b0, b.o_mem_mask}, {28'b0, vt[i].e_mask});
            chk($sformatf("vec%0d_if_gnt", i), {31'b0, b.o_if_gnt}, {31'b0, vt[i].e_ign});
            chk($sformatf("vec%0d_dm_gnt", i), {31'b0, b.o_dm_gnt}, {31'b0, vt[i].e_dgn});
            tick();
        end
        b.i_flush = 0; b.i_if_req = 0; b.i_dm_req = 0; b.i_dm_wen = 0; b.i_mem_ready = 1;
        tick();

        // Lone fetch, response two cycles after the grant.
        b.i_if_req = 1; b.i_if_addr = 32'h100;
        #2;
        chk("A_if_gnt", {31'b0, b.o_if_gnt}, 1);
        chk("A_addr", b.o_mem_addr, 32'h100);
        chk("A_mask", {28'b0, b.o_mem_mask}, 32'hF);
        if_q.push_back(32'h33);
        tick();
        b.i_if_req = 0;
        #2;
        chk("A_wait_req", {31'b0, b.o_mem_req}, 0);
        tick();
        resp(32'h33, 1'b1, 1'b0);

        // Simultaneous requests with cnt=0: data first, fetch right after.
        b.i_if_req = 1; b.i_if_addr = 32'h104; b.i_dm_req = 1; b.i_dm_addr = 32'h2000; b.i_dm_wen = 0;
        #2;
        chk("B_dm_gnt", {31'b0, b.o_dm_gnt}, 1);
        chk("B_if_gnt", {31'b0, b.o_if_gnt}, 0);
        chk("B_addr", b.o_mem_addr, 32'h2000);
        dm_q.push_back(32'hA1);
        tick();
        b.i_dm_req = 0;
        #2;
        chk("B_wait_req", {31'b0, b.o_mem_req}, 0);
        tick();
        resp(32'hA1, 1'b0, 1'b1);
        #2;
        chk("B_if_gnt2", {31'b0, b.o_if_gnt}, 1);
        chk("B_addr2", b.o_mem_addr, 32'h104);
        if_q.push_back(32'hB2);
        tick();
        b.i_if_req = 0;
        resp(32'hB2, 1'b1, 1'b0);

        // Starvation: four data grants, forced fetch, then data wins again from cnt=0.
        b.i_if_req = 1; b.i_if_addr = 32'h108; b.i_dm_req = 1; b.i_dm_addr = 32'h2004;
        for (int r = 0; r < 6; r++) begin
            logic e_dm;
            e_dm = (r != 4);
            #2;
            chk($sformatf("C%0d_dm_gnt", r), {31'b0, b.o_dm_gnt}, {31'b0, e_dm});
            chk($sformatf("C%0d_if_gnt", r), {31'b0, b.o_if_gnt}, {31'b0, ~e_dm});
            if (e_dm) dm_q.push_back(32'hD0 + r);
            else if_q.push_back(32'hD0 + r);
            tick();
            resp(32'hD0 + r, ~e_dm, e_dm);
        end
        b.i_if_req = 0; b.i_dm_req = 0;

        // Flush while WAIT_I: the late response is dropped, the redirected fetch is served.
        b.i_if_req = 1; b.i_if_addr = 32'h10C;
        #2;
        chk("D_if_gnt", {31'b0, b.o_if_gnt}, 1);
        tick();
        b.i_flush = 1; b.i_if_addr = 32'h200;
        #2;
        chk("D_flush_req", {31'b0, b.o_mem_req}, 0);
        tick();
        b.i_flush = 0;
        #2;
        chk("D_drain_no_gnt", {31'b0, b.o_if_gnt}, 0);
        chk("D_drain_req", {31'b0, b.o_mem_req}, 0);
        tick(); tick();
        resp(32'hBAD, 1'b0, 1'b0);
        #2;
        chk("D_if_gnt2", {31'b0, b.o_if_gnt}, 1);
        chk("D_addr2", b.o_mem_addr, 32'h200);
        if_q.push_back(32'h13);
        tick();
        b.i_if_req = 0;
        resp(32'h13, 1'b1, 1'b0);

        // Flush coinciding with the response, then flush in IDLE blocking a lone fetch.
        b.i_if_req = 1; b.i_if_addr = 32'h110;
        #2;
        chk("E_if_gnt", {31'b0, b.o_if_gnt}, 1);
        tick();
        b.i_if_req = 0; b.i_flush = 1;
        resp(32'h99, 1'b0, 1'b0);
        b.i_flush = 0; b.i_if_req = 1; b.i_if_addr = 32'h114; b.i_mem_ready = 0;
        #2;
        chk("E_idle_req", {31'b0, b.o_mem_req}, 1);
        chk("E_idle_addr", b.o_mem_addr, 32'h114);
        tick();
        b.i_flush = 1; b.i_mem_ready = 1;
        #2;
        chk("E_flush_req", {31'b0, b.o_mem_req}, 0);
        chk("E_flush_gnt", {31'b0, b.o_if_gnt}, 0);
        tick();
        b.i_flush = 0; b.i_if_req = 0;

        // Store, then reset asserted while a store is outstanding.
        b.i_dm_req = 1; b.i_dm_wen = 1; b.i_dm_addr = 32'h3000; b.i_dm_wdata = 32'hDEADBEEF; b.i_dm_mask = 4'b0011;
        #2;
        chk("F_dm_gnt", {31'b0, b.o_dm_gnt}, 1);
        chk("F_wen", {31'b0, b.o_mem_wen}, 1);
        chk("F_addr", b.o_mem_addr, 32'h3000);
        chk("F_wdata", b.o_mem_wdata, 32'hDEADBEEF);
        chk("F_mask", {28'b0, b.o_mem_mask}, 32'h3);
        dm_q.push_back(32'h0);
        tick();
        b.i_dm_req = 0;
        resp(32'h0, 1'b0, 1'b1);
        b.i_dm_req = 1;
        #2;
        chk("F_dm_gnt2", {31'b0, b.o_dm_gnt}, 1);
        tick();
        b.i_dm_req = 0; b.i_mem_rvld = 1; b.i_mem_rdata = 32'h77;
        #1;
        chk("F_prereset_rvld", {31'b0, b.o_dm_rvld}, 1);
        i_rst_n = 1'b0; b.i_dm_req = 1;
        #1;
        zero_outs("F_rst");
        tick(); tick();
        i_rst_n = 1'b1; b.i_dm_req = 0;
        #2;
        chk("F_stale_dm_rvld", {31'b0, b.o_dm_rvld}, 0);
        chk("F_stale_if_rvld", {31'b0, b.o_if_rvld}, 0);
        tick();
        b.i_mem_rvld = 0; b.i_mem_rdata = 0;
        tick();

        chk("if_q_empty", if_q.size(), 0);
        chk("dm_q_empty", dm_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
